// File: rtl/video_mnist_color_blend.sv
`default_nettype none
// ============================================================================
// video_mnist_color_blend : per-class palette overlay (replace / half / alpha)
//                           on an AXI4-Stream pixel path, with per-frame stats
// Revision 1.0
// ============================================================================
module video_mnist_color_blend #(
  parameter int TUSER_WIDTH     = 1,
  parameter int COMPONENT_WIDTH = 8,
  parameter int COMPONENTS      = 3,
  parameter int TNUMBER_WIDTH   = 4,
  parameter int TCOUNT_WIDTH    = 4,
  parameter int NUM_CLASSES     = 10,
  parameter int ALPHA_WIDTH     = 8,
  parameter int STAT_WIDTH      = 24,
  localparam int TDATA_WIDTH    = COMPONENT_WIDTH * COMPONENTS
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     param_binary,
  input  logic [1:0]               param_blend,
  input  logic [TCOUNT_WIDTH-1:0]  param_th,
  input  logic [ALPHA_WIDTH-1:0]   param_alpha,
  input  logic                     pal_wr_en,
  input  logic [TNUMBER_WIDTH-1:0] pal_wr_addr,
  input  logic [TDATA_WIDTH-1:0]   pal_wr_data,
  input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
  input  logic                     s_axi4s_tlast,
  input  logic [TNUMBER_WIDTH-1:0] s_axi4s_tnumber,
  input  logic [TCOUNT_WIDTH-1:0]  s_axi4s_tcount,
  input  logic [TDATA_WIDTH-1:0]   s_axi4s_tdata,
  input  logic                     s_axi4s_tbinary,
  input  logic                     s_axi4s_tvalid,
  output logic                     s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
  output logic                     m_axi4s_tlast,
  output logic [TDATA_WIDTH-1:0]   m_axi4s_tdata,
  output logic                     m_axi4s_tvalid,
  input  logic                     m_axi4s_tready,
  output logic [STAT_WIDTH-1:0]    stat_count,
  output logic                     stat_valid
);

  localparam int c_CW = COMPONENT_WIDTH;
  localparam int c_AW = ALPHA_WIDTH;
  localparam int c_MW = c_CW + c_AW + 1;
  localparam int c_IW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [c_MW-1:0]          c_ROUND = c_MW'(1) << (c_AW - 1);
  localparam logic [TNUMBER_WIDTH:0]   c_NUM   = NUM_CLASSES[TNUMBER_WIDTH:0];

  // 8-bit RGB reference colours, left-aligned into each component width
  function automatic logic [TDATA_WIDTH-1:0] f_default_color(input int idx);
    logic [31:0]            rgb;
    logic [c_CW+7:0]        t;
    logic [TDATA_WIDTH-1:0] res;
    case (idx)
      0:       rgb = 32'h000000;
      1:       rgb = 32'h800000;
      2:       rgb = 32'hFF0000;
      3:       rgb = 32'hFFB74C;
      4:       rgb = 32'hFFFF00;
      5:       rgb = 32'h008000;
      6:       rgb = 32'h0000FF;
      7:       rgb = 32'h800080;
      8:       rgb = 32'h808080;
      9:       rgb = 32'hFFFFFF;
      default: rgb = 32'h000000;
    endcase
    res = '0;
    for (int k = 0; k < COMPONENTS; k++) begin
      if (k < 3) begin
        t = {rgb[k*8 +: 8], {c_CW{1'b0}}};
        res[k*c_CW +: c_CW] = t[c_CW+7 -: c_CW];
      end
    end
    return res;
  endfunction

  logic [TDATA_WIDTH-1:0] r_pal [NUM_CLASSES];
  logic                   w_ready;
  logic                   w_wr_in_range;
  logic                   w_num_in_range;
  logic                   w_ovl_en;
  logic                   w_out_fire;
  logic [c_IW-1:0]        w_wr_idx;
  logic [TDATA_WIDTH-1:0] w_rd_color;
  logic [TDATA_WIDTH-1:0] w_src;
  logic [c_AW:0]          w_inv;
  logic [TDATA_WIDTH-1:0] w_out;
  logic [COMPONENTS-1:0][c_CW:0]   w_half;
  logic [COMPONENTS-1:0][c_MW-1:0] w_blend;

  logic                   r0_valid, r0_last, r0_ovl;
  logic [TUSER_WIDTH-1:0] r0_user;
  logic [TDATA_WIDTH-1:0] r0_data, r0_color;
  logic [1:0]             r0_mode;
  logic [c_AW-1:0]        r0_alpha;

  logic                   r1_valid, r1_last, r1_ovl;
  logic [TUSER_WIDTH-1:0] r1_user;
  logic [TDATA_WIDTH-1:0] r1_data, r1_color;
  logic [1:0]             r1_mode;
  logic [COMPONENTS-1:0][c_CW:0]   r1_half;
  logic [COMPONENTS-1:0][c_MW-1:0] r1_blend;

  logic                   r2_valid, r2_last, r2_ovl;
  logic [TUSER_WIDTH-1:0] r2_user;
  logic [TDATA_WIDTH-1:0] r2_data;

  logic [STAT_WIDTH-1:0]  r_cnt;
  logic [STAT_WIDTH-1:0]  r_stat_count;
  logic                   r_stat_valid;

  assign w_ready        = m_axi4s_tready || !r2_valid;
  assign s_axi4s_tready = w_ready;
  assign w_out_fire     = r2_valid && m_axi4s_tready;

  assign w_wr_in_range  = {1'b0, pal_wr_addr} < c_NUM;
  assign w_num_in_range = {1'b0, s_axi4s_tnumber} < c_NUM;
  assign w_wr_idx       = pal_wr_addr[c_IW-1:0];
  assign w_rd_color     = r_pal[s_axi4s_tnumber[c_IW-1:0]];
  assign w_src          = param_binary ? {TDATA_WIDTH{s_axi4s_tbinary}} : s_axi4s_tdata;
  assign w_ovl_en       = (param_blend != 2'd0) && (s_axi4s_tcount >= param_th) && w_num_in_range;

  // Palette writes are not gated by the stall; a read in the write cycle sees the old entry
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_CLASSES; i++) r_pal[i] <= f_default_color(i);
    end else if (pal_wr_en && w_wr_in_range) begin
      r_pal[w_wr_idx] <= pal_wr_data;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r0_valid <= 1'b0;
      r0_user  <= '0;
      r0_last  <= 1'b0;
      r0_data  <= '0;
      r0_color <= '0;
      r0_ovl   <= 1'b0;
      r0_mode  <= 2'd0;
      r0_alpha <= '0;
    end else if (w_ready) begin
      r0_valid <= s_axi4s_tvalid;
      r0_user  <= s_axi4s_tuser;
      r0_last  <= s_axi4s_tlast;
      r0_data  <= w_src;
      r0_color <= w_rd_color;
      r0_ovl   <= w_ovl_en;
      r0_mode  <= param_blend;
      r0_alpha <= param_alpha;
    end
  end

  assign w_inv = {1'b1, {c_AW{1'b0}}} - {1'b0, r0_alpha};

  for (genvar k = 0; k < COMPONENTS; k++) begin : g_comp
    logic [c_CW-1:0] w_d0, w_c0, w_d1, w_c1;
    assign w_d0 = r0_data[k*c_CW +: c_CW];
    assign w_c0 = r0_color[k*c_CW +: c_CW];
    assign w_half[k]  = {1'b0, w_d0} + {1'b0, w_c0};
    assign w_blend[k] = ({{(c_AW+1){1'b0}}, w_c0} * {{(c_CW+1){1'b0}}, r0_alpha})
                      + ({{(c_AW+1){1'b0}}, w_d0} * {{c_CW{1'b0}}, w_inv})
                      + c_ROUND;
    assign w_d1 = r1_data[k*c_CW +: c_CW];
    assign w_c1 = r1_color[k*c_CW +: c_CW];
    assign w_out[k*c_CW +: c_CW] = !r1_ovl            ? w_d1 :
                                   (r1_mode == 2'd1)  ? w_c1 :
                                   (r1_mode == 2'd2)  ? r1_half[k][c_CW:1] :
                                   (r1_mode == 2'd3)  ? r1_blend[k][c_AW +: c_CW] :
                                                        w_d1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r1_valid <= 1'b0;
      r1_user  <= '0;
      r1_last  <= 1'b0;
      r1_data  <= '0;
      r1_color <= '0;
      r1_half  <= '0;
      r1_blend <= '0;
      r1_ovl   <= 1'b0;
      r1_mode  <= 2'd0;
    end else if (w_ready) begin
      r1_valid <= r0_valid;
      r1_user  <= r0_user;
      r1_last  <= r0_last;
      r1_data  <= r0_data;
      r1_color <= r0_color;
      r1_half  <= w_half;
      r1_blend <= w_blend;
      r1_ovl   <= r0_ovl;
      r1_mode  <= r0_mode;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r2_valid <= 1'b0;
      r2_user  <= '0;
      r2_last  <= 1'b0;
      r2_data  <= '0;
      r2_ovl   <= 1'b0;
    end else if (w_ready) begin
      r2_valid <= r1_valid;
      r2_user  <= r1_user;
      r2_last  <= r1_last;
      r2_data  <= w_out;
      r2_ovl   <= r1_ovl;
    end
  end

  // Frame-start beat closes the previous frame and seeds the new count with itself
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt        <= '0;
      r_stat_count <= '0;
      r_stat_valid <= 1'b0;
    end else begin
      r_stat_valid <= 1'b0;
      if (w_out_fire) begin
        if (r2_user[0]) begin
          r_stat_count <= r_cnt;
          r_stat_valid <= 1'b1;
          r_cnt        <= r2_ovl ? STAT_WIDTH'(1) : '0;
        end else if (r2_ovl && !(&r_cnt)) begin
          r_cnt <= r_cnt + STAT_WIDTH'(1);
        end
      end
    end
  end

  assign m_axi4s_tvalid = r2_valid;
  assign m_axi4s_tuser  = r2_user;
  assign m_axi4s_tlast  = r2_last;
  assign m_axi4s_tdata  = r2_data;
  assign stat_count     = r_stat_count;
  assign stat_valid     = r_stat_valid;

endmodule
`default_nettype wire

// File: tb/tb_video_mnist_color_blend.sv
`default_nettype none
// ============================================================================
// tb_video_mnist_color_blend : table vectors, randomized backpressure against a
//                              reference model, statistics and reset sequences
// Revision 1.0
// ============================================================================
module tb_video_mnist_color_blend;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic        param_binary = 1'b0;
  logic [1:0]  param_blend = 2'd0;
  logic [3:0]  param_th = 4'd0;
  logic [7:0]  param_alpha = 8'd0;
  logic        pal_wr_en = 1'b0;
  logic [3:0]  pal_wr_addr = 4'd0;
  logic [23:0] pal_wr_data = 24'd0;
  logic [0:0]  s_axi4s_tuser = 1'b0;
  logic        s_axi4s_tlast = 1'b0;
  logic [3:0]  s_axi4s_tnumber = 4'd0;
  logic [3:0]  s_axi4s_tcount = 4'd0;
  logic [23:0] s_axi4s_tdata = 24'd0;
  logic        s_axi4s_tbinary = 1'b0;
  logic        s_axi4s_tvalid = 1'b0;
  logic        s_axi4s_tready;
  logic [0:0]  m_axi4s_tuser;
  logic        m_axi4s_tlast;
  logic [23:0] m_axi4s_tdata;
  logic        m_axi4s_tvalid;
  logic        m_axi4s_tready = 1'b1;
  logic [23:0] stat_count;
  logic        stat_valid;

  video_mnist_color_blend dut (
    .aclk(aclk), .aresetn(aresetn),
    .param_binary(param_binary), .param_blend(param_blend), .param_th(param_th),
    .param_alpha(param_alpha), .pal_wr_en(pal_wr_en), .pal_wr_addr(pal_wr_addr),
    .pal_wr_data(pal_wr_data), .s_axi4s_tuser(s_axi4s_tuser), .s_axi4s_tlast(s_axi4s_tlast),
    .s_axi4s_tnumber(s_axi4s_tnumber), .s_axi4s_tcount(s_axi4s_tcount),
    .s_axi4s_tdata(s_axi4s_tdata), .s_axi4s_tbinary(s_axi4s_tbinary),
    .s_axi4s_tvalid(s_axi4s_tvalid), .s_axi4s_tready(s_axi4s_tready),
    .m_axi4s_tuser(m_axi4s_tuser), .m_axi4s_tlast(m_axi4s_tlast),
    .m_axi4s_tdata(m_axi4s_tdata), .m_axi4s_tvalid(m_axi4s_tvalid),
    .m_axi4s_tready(m_axi4s_tready), .stat_count(stat_count), .stat_valid(stat_valid)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic        user, last, bin, tbin, wr;
    logic [3:0]  num, cnt, th, waddr;
    logic [23:0] data, wdata, exp;
    logic [1:0]  blend;
    logic [7:0]  alpha;
  } vec_t;

  typedef struct {
    logic [23:0] data;
    logic        user, last, ovl;
    int          cyc;
    bit          tab, lat;
  } exp_t;

  exp_t        q_exp[$];
  logic [23:0] q_tab[$];
  int          q_stat_seen[$];
  logic [23:0] mpal[10];
  logic [23:0] c_col[10];
  vec_t        tab[30];

  int n_checks = 0;
  int n_err    = 0;
  int cycle    = 0;
  bit tab_mode = 0, lat_check = 0, rand_bp = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic void pal_reset();
    mpal = '{24'h000000, 24'h800000, 24'hFF0000, 24'hFFB74C, 24'hFFFF00,
             24'h008000, 24'h0000FF, 24'h800080, 24'h808080, 24'hFFFFFF};
  endfunction

  // Reference: per-component integer arithmetic on the values presented at acceptance
  function automatic exp_t model();
    exp_t        e;
    logic [23:0] src, res, col;
    int          d, c, r, a;
    src = param_binary ? {24{s_axi4s_tbinary}} : s_axi4s_tdata;
    e.ovl = (param_blend != 0) && (s_axi4s_tcount >= param_th) && (s_axi4s_tnumber < 10);
    res = src;
    a = param_alpha;
    if (e.ovl) begin
      col = mpal[s_axi4s_tnumber];
      for (int k = 0; k < 3; k++) begin
        d = src[8*k +: 8];
        c = col[8*k +: 8];
        case (param_blend)
          2'd1:    r = c;
          2'd2:    r = (d + c) / 2;
          default: r = (c * a + d * (256 - a) + 128) / 256;
        endcase
        res[8*k +: 8] = r[7:0];
      end
    end
    e.data = res;
    e.user = s_axi4s_tuser[0];
    e.last = s_axi4s_tlast;
    e.cyc  = 0;
    e.tab  = 0;
    e.lat  = 0;
    return e;
  endfunction

  always @(posedge aclk) cycle <= cycle + 1;

  always @(posedge aclk) begin
    #1;
    m_axi4s_tready = rand_bp ? ($urandom_range(0, 99) < 60) : 1'b1;
  end

  // Input observer: predicts each accepted beat, then tracks palette writes
  always @(negedge aclk) begin
    exp_t e;
    if (!aresetn) begin
      q_exp.delete();
      q_tab.delete();
      pal_reset();
    end else begin
      if (s_axi4s_tvalid && s_axi4s_tready) begin
        e     = model();
        e.cyc = cycle;
        e.tab = tab_mode;
        e.lat = lat_check;
        q_exp.push_back(e);
      end
      if (pal_wr_en && pal_wr_addr < 10) mpal[pal_wr_addr] = pal_wr_data;
    end
  end

  // Output monitor: data, hold-while-stalled, latency and frame statistics
  int          m_cnt = 0;
  bit          stat_pend = 0, prev_stall = 0;
  int          stat_pend_val = 0;
  logic [23:0] h_data;
  logic        h_user, h_last;
  always @(negedge aclk) begin
    exp_t        e;
    logic [23:0] t;
    if (!aresetn) begin
      m_cnt = 0;
      stat_pend = 0;
      prev_stall = 0;
    end else begin
      chk("stat_valid", stat_valid, stat_pend);
      if (stat_pend) chk("stat_count", stat_count, stat_pend_val);
      if (stat_valid) q_stat_seen.push_back(stat_count);
      stat_pend = 0;
      if (prev_stall) begin
        chk("hold_tvalid", m_axi4s_tvalid, 1'b1);
        chk("hold_tdata", m_axi4s_tdata, h_data);
        chk("hold_tuser", m_axi4s_tuser, h_user);
        chk("hold_tlast", m_axi4s_tlast, h_last);
      end
      prev_stall = m_axi4s_tvalid && !m_axi4s_tready;
      h_data = m_axi4s_tdata;
      h_user = m_axi4s_tuser[0];
      h_last = m_axi4s_tlast;
      if (m_axi4s_tvalid && m_axi4s_tready) begin
        if (q_exp.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_beat: actual tdata=%0h required no beat", m_axi4s_tdata);
        end else begin
          e = q_exp.pop_front();
          chk("model_tdata", m_axi4s_tdata, e.data);
          chk("model_tuser", m_axi4s_tuser, e.user);
          chk("model_tlast", m_axi4s_tlast, e.last);
          if (e.tab && q_tab.size() != 0) begin
            t = q_tab.pop_front();
            chk("table_tdata", m_axi4s_tdata, t);
          end
          if (e.lat) chk("latency", 64'(cycle - e.cyc), 3);
          if (m_axi4s_tuser[0]) begin
            stat_pend = 1;
            stat_pend_val = m_cnt;
            m_cnt = e.ovl ? 1 : 0;
          end else if (e.ovl && m_cnt != 24'hFFFFFF) begin
            m_cnt++;
          end
        end
      end
    end
  end

  function automatic vec_t mk(input logic [3:0] num, input logic [3:0] cnt, input logic [23:0] data,
                              input logic [1:0] blend, input logic [3:0] th,
                              input logic [7:0] alpha, input logic [23:0] exp);
    vec_t v;
    v.user = 0; v.last = 0; v.bin = 0; v.tbin = 0; v.wr = 0; v.waddr = 0; v.wdata = 0;
    v.num = num; v.cnt = cnt; v.data = data; v.blend = blend; v.th = th;
    v.alpha = alpha; v.exp = exp;
    return v;
  endfunction

  // Presents one beat from just after a clock edge until it is accepted
  task automatic send(input vec_t b, input bit has_exp);
    int t;
    s_axi4s_tuser   = b.user;  s_axi4s_tlast  = b.last;  s_axi4s_tnumber = b.num;
    s_axi4s_tcount  = b.cnt;   s_axi4s_tdata  = b.data;  s_axi4s_tbinary = b.tbin;
    param_binary    = b.bin;   param_blend    = b.blend; param_th        = b.th;
    param_alpha     = b.alpha; pal_wr_en      = b.wr;    pal_wr_addr     = b.waddr;
    pal_wr_data     = b.wdata; s_axi4s_tvalid = 1'b1;
    t = 0;
    do begin
      @(negedge aclk);
      t++;
    end while (!s_axi4s_tready && t < 1000);
    if (!s_axi4s_tready) begin
      n_checks++;
      n_err++;
      $display("FAIL accept_timeout: actual tready=0 required 1 within 1000 cycles");
    end else if (has_exp) begin
      q_tab.push_back(b.exp);
    end
    @(posedge aclk);
    #1;
    s_axi4s_tvalid = 1'b0;
    pal_wr_en      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    while (q_exp.size() != 0 && t < 2000) begin
      @(negedge aclk);
      t++;
    end
    chk("drain_pending", q_exp.size(), 0);
    idle(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual still running required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t b;
    pal_reset();
    c_col = '{24'h000000, 24'h800000, 24'hFF0000, 24'hFFB74C, 24'hFFFF00,
              24'h008000, 24'h0000FF, 24'h800080, 24'h808080, 24'hFFFFFF};

    #1 aresetn = 1'b0;
    #10;
    chk("rst_tvalid", m_axi4s_tvalid, 0);
    chk("rst_tdata", m_axi4s_tdata, 0);
    chk("rst_tuser", m_axi4s_tuser, 0);
    chk("rst_tlast", m_axi4s_tlast, 0);
    chk("rst_stat_count", stat_count, 0);
    chk("rst_stat_valid", stat_valid, 0);
    chk("rst_tready", s_axi4s_tready, 1);
    @(posedge aclk);
    #3 aresetn = 1'b1;
    idle(2);

    for (int i = 0; i < 10; i++) tab[i] = mk(4'(i), 4'd3, 24'h5A5A5A, 2'd1, 4'd3, 8'h00, c_col[i]);
    for (int i = 0; i < 10; i++) tab[10+i] = mk(4'(i), 4'd2, 24'h102030 + 24'(i), 2'd1, 4'd3, 8'h00, 24'h102030 + 24'(i));
    tab[0].user = 1;
    tab[20] = mk(4'd9, 4'd3, 24'h404040, 2'd3, 4'd3, 8'h80, 24'hA0A0A0);
    tab[21] = mk(4'd9, 4'd3, 24'h404040, 2'd3, 4'd3, 8'h00, 24'h404040);
    tab[22] = mk(4'd2, 4'd3, 24'h010101, 2'd2, 4'd3, 8'h00, 24'h800000);
    tab[23] = mk(4'd5, 4'd3, 24'h000000, 2'd1, 4'd3, 8'h00, 24'h008000);
    tab[23].wr = 1; tab[23].waddr = 4'd5; tab[23].wdata = 24'h123456;
    tab[24] = mk(4'd5, 4'd3, 24'h000000, 2'd1, 4'd3, 8'h00, 24'h123456);
    tab[25] = mk(4'd5, 4'd3, 24'h000000, 2'd1, 4'd3, 8'h00, 24'h123456);
    tab[25].wr = 1; tab[25].waddr = 4'd12; tab[25].wdata = 24'hABCDEF;
    tab[26] = mk(4'd5, 4'd3, 24'h000000, 2'd1, 4'd3, 8'h00, 24'h123456);
    tab[27] = mk(4'd3, 4'd0, 24'h000000, 2'd0, 4'd3, 8'h00, 24'hFFFFFF);
    tab[27].bin = 1; tab[27].tbin = 1;
    tab[28] = mk(4'd15, 4'd15, 24'hC0FFEE, 2'd1, 4'd0, 8'h00, 24'hC0FFEE);
    tab[29] = mk(4'd4, 4'd0, 24'h112233, 2'd1, 4'd0, 8'h00, 24'hFFFF00);

    tab_mode = 1; lat_check = 1;
    for (int i = 0; i < 30; i++) send(tab[i], 1'b1);
    tab_mode = 0; lat_check = 0;
    drain();

    rand_bp = 1;
    for (int i = 0; i < 256; i++) begin
      b = mk(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 24'($urandom),
             2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 8'($urandom), 24'h0);
      b.user  = (i == 0);
      b.last  = (i % 64 == 63);
      b.bin   = ($urandom_range(0, 7) == 0);
      b.tbin  = 1'($urandom);
      b.wr    = ($urandom_range(0, 15) == 0);
      b.waddr = 4'($urandom_range(0, 15));
      b.wdata = 24'($urandom);
      send(b, 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_bp = 0;
    drain();

    q_stat_seen.delete();
    for (int i = 0; i < 45; i++) begin
      b = mk(4'(i % 10), (i < 37) ? 4'd3 : 4'd0, 24'(i), 2'd1, 4'd3, 8'h00, 24'h0);
      b.user = (i == 0);
      send(b, 1'b0);
    end
    for (int i = 0; i < 12; i++) begin
      b = mk(4'(i % 10), (i < 5) ? 4'd3 : 4'd0, 24'h777777, 2'd2, 4'd3, 8'h00, 24'h0);
      b.user = (i == 0);
      send(b, 1'b0);
    end
    b = mk(4'd0, 4'd0, 24'h0, 2'd1, 4'd3, 8'h00, 24'h0);
    b.user = 1;
    send(b, 1'b0);
    drain();
    chk("stat_pulses", q_stat_seen.size(), 3);
    if (q_stat_seen.size() >= 3) begin
      chk("stat_frame37", q_stat_seen[1], 37);
      chk("stat_frame5", q_stat_seen[2], 5);
    end

    for (int i = 0; i < 4; i++) begin
      b = mk(4'd5, 4'd3, 24'h0, 2'd1, 4'd3, 8'h00, 24'h0);
      b.user = (i == 0);
      send(b, 1'b0);
    end
    #1 aresetn = 1'b0;
    #1;
    chk("midrst_tvalid", m_axi4s_tvalid, 0);
    chk("midrst_tdata", m_axi4s_tdata, 0);
    chk("midrst_stat_count", stat_count, 0);
    chk("midrst_stat_valid", stat_valid, 0);
    chk("midrst_tready", s_axi4s_tready, 1);
    @(posedge aclk);
    @(posedge aclk);
    #3 aresetn = 1'b1;
    idle(2);

    tab_mode = 1; lat_check = 1;
    b = mk(4'd5, 4'd3, 24'h0, 2'd1, 4'd3, 8'h00, 24'h008000);
    send(b, 1'b1);
    tab_mode = 0; lat_check = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
